// File: rtl/pushsw_event_reg.sv
// Push-switch responder on the local bus: it synchronises and debounces active-low pins,
// latches sticky press/release events (write-1-to-clear) and raises a registered interrupt flag.
module pushsw_event_reg #(
  parameter int          NSW              = 4,
  parameter int          XLEN             = 32,
  parameter int          AWIDTH           = 16,
  parameter logic [15:0] DEBOUNCE_DEFAULT = 16'd1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic [AWIDTH-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [2:0]        we,
  output logic [XLEN-1:0]   rdata,
  input  logic [NSW-1:0]    sw_n,
  output logic              irq
);

  logic [NSW-1:0] sync1_reg;
  logic [NSW-1:0] sync2_reg;
  logic [NSW-1:0] stable_reg;
  logic [NSW-1:0] stable_next;
  logic [NSW-1:0] press_evt_reg;
  logic [NSW-1:0] release_evt_reg;
  logic [NSW-1:0] press_set;
  logic [NSW-1:0] release_set;
  logic [NSW-1:0] press_clr;
  logic [NSW-1:0] release_clr;
  logic [15:0]    thresh_reg;
  logic [15:0]    eff_m1;
  logic           irq_en_reg;
  logic           irq_reg;
  logic           wr_en;
  logic [1:0]     word_sel;
  logic           unused_bits;

  assign word_sel    = addr[3:2];
  assign wr_en       = sel & (we != 3'd0);
  assign unused_bits = ^{addr[AWIDTH-1:4], addr[1:0], wdata[XLEN-1:17]};

  // A threshold of 0 behaves like 1, so the terminal count is 0 in both cases.
  assign eff_m1 = (thresh_reg == 16'd0) ? 16'd0 : thresh_reg - 16'd1;

  assign press_clr   = (wr_en && word_sel == 2'd1) ? wdata[NSW-1:0] : '0;
  assign release_clr = (wr_en && word_sel == 2'd2) ? wdata[NSW-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NSW; gi++) begin : g_ch
      logic        pressed_s;
      logic        mismatch;
      logic        commit;
      logic [15:0] cnt_reg;
      logic [15:0] cnt_next;

      assign pressed_s = ~sync2_reg[gi];
      assign mismatch  = pressed_s ^ stable_reg[gi];
      // ">=" lets a channel commit at once when the threshold is lowered below its count.
      assign commit    = mismatch & (cnt_reg >= eff_m1);
      assign cnt_next  = (!mismatch || commit) ? 16'd0 : cnt_reg + 16'd1;

      assign stable_next[gi] = commit ? pressed_s : stable_reg[gi];
      assign press_set[gi]   = commit & pressed_s;
      assign release_set[gi] = commit & ~pressed_s;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= 16'd0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg       <= '1;
      sync2_reg       <= '1;
      stable_reg      <= '0;
      press_evt_reg   <= '0;
      release_evt_reg <= '0;
      thresh_reg      <= DEBOUNCE_DEFAULT;
      irq_en_reg      <= 1'b0;
      irq_reg         <= 1'b0;
    end else begin
      sync1_reg       <= sw_n;
      sync2_reg       <= sync1_reg;
      stable_reg      <= stable_next;
      // A new event outranks a same-cycle clear of that bit.
      press_evt_reg   <= (press_evt_reg & ~press_clr) | press_set;
      release_evt_reg <= (release_evt_reg & ~release_clr) | release_set;
      irq_reg         <= irq_en_reg & ((|press_evt_reg) | (|release_evt_reg));
      if (wr_en && word_sel == 2'd3) begin
        thresh_reg <= wdata[15:0];
        irq_en_reg <= wdata[16];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (word_sel)
        2'd0: rdata[NSW-1:0] = stable_reg;
        2'd1: rdata[NSW-1:0] = press_evt_reg;
        2'd2: rdata[NSW-1:0] = release_evt_reg;
        default: begin
          rdata[15:0] = thresh_reg;
          rdata[16]   = irq_en_reg;
        end
      endcase
    end
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_pushsw_event_reg.sv
// Bench for pushsw_event_reg: directed latency/corner sequences, then random traffic,
// all checked against a cycle-level reference model of the debounce and event rules.
module tb_pushsw_event_reg;
  localparam int NSW    = 4;
  localparam int XLEN   = 32;
  localparam int AWIDTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sel;
  logic [AWIDTH-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [2:0]        we;
  logic [XLEN-1:0]   rdata;
  logic [NSW-1:0]    sw_n;
  logic              irq;

  always #5 clk = ~clk;

  pushsw_event_reg #(
    .NSW(NSW), .XLEN(XLEN), .AWIDTH(AWIDTH), .DEBOUNCE_DEFAULT(16'd1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata),
    .we(we), .rdata(rdata), .sw_n(sw_n), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: pressed levels delayed two edges, per-channel run length of disagreement.
  logic [NSW-1:0] m_stab, m_pe, m_re;
  logic [15:0]    m_thr;
  logic           m_ien, m_irq;
  int             m_run[NSW];
  logic [NSW-1:0] m_pipe[$];

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0:       return 32'(m_stab);
      1:       return 32'(m_pe);
      2:       return 32'(m_re);
      default: return {15'd0, m_ien, m_thr};
    endcase
  endfunction

  // One clock edge with the given inputs; the model advances alongside.
  task automatic step(input logic r, input logic s_sel, input int a,
                      input logic [31:0] wd, input logic [2:0] w, input logic [NSW-1:0] sw);
    logic [NSW-1:0] s, set_p, set_r, clr_p, clr_r;
    int eff;
    logic wr;
    rst_n = r; sel = s_sel; addr = 16'(a * 4); wdata = wd; we = w; sw_n = sw;
    if (!r) begin
      m_stab = '0; m_pe = '0; m_re = '0; m_thr = 16'd1000; m_ien = 1'b0; m_irq = 1'b0;
      for (int i = 0; i < NSW; i++) m_run[i] = 0;
      m_pipe.delete();
      m_pipe.push_back('0);
      m_pipe.push_back('0);
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(~sw);
      eff = (m_thr == 0) ? 1 : int'(m_thr);
      m_irq = m_ien & ((|m_pe) | (|m_re));
      set_p = '0; set_r = '0;
      for (int i = 0; i < NSW; i++) begin
        if (s[i] == m_stab[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= eff) begin
          m_stab[i] = s[i];
          m_run[i] = 0;
          if (s[i]) set_p[i] = 1'b1; else set_r[i] = 1'b1;
        end else m_run[i]++;
      end
      wr = s_sel && (w != 3'd0);
      clr_p = (wr && a == 1) ? wd[NSW-1:0] : '0;
      clr_r = (wr && a == 2) ? wd[NSW-1:0] : '0;
      m_pe = (m_pe & ~clr_p) | set_p;
      m_re = (m_re & ~clr_r) | set_r;
      if (wr && a == 3) begin
        m_thr = wd[15:0];
        m_ien = wd[16];
      end
    end
    @(posedge clk);
    #1;
    sel = 1'b0; we = 3'd0; rst_n = 1'b1;
  endtask

  task automatic read_reg(input int a, output logic [31:0] v);
    sel = 1'b1; we = 3'd0; addr = 16'(a * 4);
    #1;
    v = rdata;
    sel = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 4; a++) begin
      read_reg(a, v);
      check_val($sformatf("%s reg%0d", tag, a), v, exp_reg(a));
    end
    check_val({tag, " irq"}, 32'(irq), 32'(m_irq));
    sel = 1'b0; addr = 16'($urandom_range(0, 3) * 4);
    #1;
    check_val({tag, " sel0"}, rdata, 32'd0);
  endtask

  task automatic idle(input int n, input logic [NSW-1:0] sw);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, 32'd0, 3'd0, sw);
  endtask

  logic [31:0]    v;
  logic [NSW-1:0] sw_held;
  int             op;

  initial begin
    rst_n = 1'b0; sel = 1'b0; addr = '0; wdata = '0; we = 3'd0; sw_n = '1;
    step(1'b0, 1'b0, 0, 32'd0, 3'd0, 4'hF);
    idle(100, 4'hF);
    check_all("reset");
    read_reg(3, v); check_val("reset config", v, 32'h0000_03E8);

    // Press ch1 with thresh=4: commit at edge 5, irq at edge 6.
    step(1'b1, 1'b1, 3, 32'h0001_0004, 3'd1, 4'hF);
    check_all("cfg");
    step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hD);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hD);
      check_all($sformatf("lat e%0d", k));
      read_reg(1, v);
      check_val($sformatf("lat press e%0d", k), v, (k >= 5) ? 32'h2 : 32'h0);
      check_val($sformatf("lat irq e%0d", k), 32'(irq), (k >= 6) ? 32'd1 : 32'd0);
    end

    // 3-cycle glitch on ch0 is rejected; 4-cycle hold is accepted.
    for (int k = 0; k < 3; k++) begin step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hC); check_all("glitch"); end
    for (int k = 0; k < 8; k++) begin step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hD); check_all("glitch gap"); end
    read_reg(0, v); check_val("glitch status", v, 32'h2);
    for (int k = 0; k < 8; k++) begin step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hC); check_all("press0"); end
    read_reg(1, v); check_val("press0 evt", v, 32'h3);
    step(1'b1, 1'b1, 1, 32'h1, 3'd4, 4'hC);
    read_reg(1, v); check_val("w1c partial", v, 32'h2);

    // Release ch0 held long enough.
    for (int k = 0; k < 8; k++) begin step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hD); check_all("rel0"); end
    read_reg(2, v); check_val("rel0 evt", v, 32'h1);

    // Re-press ch1 and clear it on the exact commit edge.
    for (int k = 0; k < 8; k++) begin step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hF); check_all("rel1"); end
    step(1'b1, 1'b1, 1, 32'hF, 3'd2, 4'hF);
    step(1'b1, 1'b1, 2, 32'hF, 3'd2, 4'hF);
    check_all("clr all");
    step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'hD);
    idle(4, 4'hD);
    step(1'b1, 1'b1, 1, 32'h2, 3'd7, 4'hD);
    check_all("set wins");
    read_reg(1, v); check_val("set wins evt", v, 32'h2);

    // Ignored writes: STATUS, and any write with sel=0.
    step(1'b1, 1'b1, 0, 32'hF, 3'd1, 4'hD);
    step(1'b1, 1'b0, 3, 32'h0000_0009, 3'd1, 4'hD);
    check_all("ignored wr");

    // thresh=0 acts as 1: ch2 commits at edge 2.
    step(1'b1, 1'b1, 3, 32'h0001_0000, 3'd1, 4'hD);
    step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'h9);
    for (int k = 1; k <= 2; k++) begin
      step(1'b1, 1'b0, 0, 32'd0, 3'd0, 4'h9);
      check_all("eff1");
      read_reg(0, v);
      check_val($sformatf("eff1 ch2 e%0d", k), 32'(v[2]), (k >= 2) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a count with events pending.
    step(1'b1, 1'b1, 3, 32'h0001_000A, 3'd1, 4'hF);
    idle(4, 4'hF);
    step(1'b0, 1'b0, 0, 32'd0, 3'd0, 4'hF);
    idle(20, 4'hF);
    check_all("mid reset");
    read_reg(1, v); check_val("mid reset press", v, 32'h0);
    read_reg(2, v); check_val("mid reset release", v, 32'h0);
    read_reg(3, v); check_val("mid reset config", v, 32'h0000_03E8);

    // Random traffic.
    step(1'b1, 1'b1, 3, 32'h0001_0003, 3'd1, 4'hF);
    sw_held = 4'hF;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NSW; i++)
        if ($urandom_range(0, 5) == 0) sw_held[i] = ~sw_held[i];
      op = $urandom_range(0, 99);
      if (op < 2)
        step(1'b0, 1'b0, 0, 32'd0, 3'd0, sw_held);
      else if (op < 10)
        step(1'b1, 1'b1, $urandom_range(1, 2), $urandom, 3'($urandom_range(1, 7)), sw_held);
      else if (op < 14)
        step(1'b1, 1'b1, 3, {$urandom_range(0, 32767), 1'($urandom), 16'($urandom_range(0, 7))},
             3'($urandom_range(1, 7)), sw_held);
      else if (op < 16)
        step(1'b1, 1'b1, 0, $urandom, 3'($urandom_range(1, 7)), sw_held);
      else if (op < 20)
        step(1'b1, 1'b0, $urandom_range(0, 3), $urandom, 3'($urandom_range(1, 7)), sw_held);
      else
        step(1'b1, 1'b1, $urandom_range(0, 3), $urandom, 3'd0, sw_held);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
